boreal_frame_unpacker: RTL and testbench

//  Consumes the 792-bit frame from the ADS1299 SPI daisy-chain capture stage. Splits it into 33 x 24-bit words.

---
 rtl/boreal_pkg.sv | 15 +
 rtl/boreal_frame_unpacker.sv | 145 ++++++++++++++
 tb/tb_boreal_frame_unpacker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/boreal_pkg.sv
// Shared constants and state encoding for the Boreal ADS1299 frame capture/unpack path.
package boreal_pkg;

    localparam int BOREAL_FRAME_WORDS = 33;
    localparam int BOREAL_WORD_W      = 24;
    localparam int BOREAL_FRAME_W     = BOREAL_FRAME_WORDS * BOREAL_WORD_W;

    localparam logic [3:0] BOREAL_STATUS_HDR = 4'hC;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } boreal_state_e;

endpackage

// File: rtl/boreal_frame_unpacker.sv
// Splits a captured ADS1299 daisy-chain frame into sign-extended words on a valid/ready stream.
// Optional status-header check on frame acceptance: define BOREAL_UNPACK_STATUS_CHECK_EN.
module boreal_frame_unpacker
    import boreal_pkg::*;
#(
    parameter int WORDS  = BOREAL_FRAME_WORDS,
    parameter int WORD_W = BOREAL_WORD_W,
    parameter int OUT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WORDS*WORD_W-1:0] frame_in,
    input  logic                    frame_valid,
    output logic [OUT_W-1:0]        m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [5:0]              m_index,
    output logic                    m_last,
    output logic                    busy,
    output logic [15:0]             drop_count,
    output logic [15:0]             sync_err
);

    localparam int         FRAME_W  = WORDS * WORD_W;
    localparam logic [5:0] LAST_IDX = 6'(WORDS - 1);

    boreal_state_e      state_q, state_d;
    logic [FRAME_W-1:0] buf_q, buf_d;
    logic [5:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [15:0]        drop_q, drop_d;
`ifdef BOREAL_UNPACK_STATUS_CHECK_EN
    logic [15:0]        sync_q, sync_d;
`endif

    logic              hs;
    logic              accept;
    logic              hdr_ok;
    logic [WORD_W-1:0] word;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        drop_d  = drop_q;
`ifdef BOREAL_UNPACK_STATUS_CHECK_EN
        sync_d  = sync_q;
        hdr_ok  = (frame_in[FRAME_W-1 -: 4] == BOREAL_STATUS_HDR);
`else
        hdr_ok  = 1'b1;
`endif
        accept  = 1'b0;
        hs      = valid_q & m_ready;
        word    = '0;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid) accept = 1'b1;
            end
            ST_STREAM: begin
                if (hs && last_q) begin
                    // A strobe coinciding with the final handshake chains straight into the next frame.
                    if (frame_valid) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end
                end else begin
                    if (hs) idx_d = idx_q + 6'd1;
                    if (frame_valid && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            idx_d = '0;
            if (hdr_ok) begin
                buf_d   = frame_in;
                state_d = ST_STREAM;
                valid_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
`ifdef BOREAL_UNPACK_STATUS_CHECK_EN
                if (sync_q != 16'hFFFF) sync_d = sync_q + 16'd1;
`endif
            end
        end

        // Word 0 sits in the frame MSBs; constant slices keep the mux lint-clean.
        for (int k = 0; k < WORDS; k++) begin
            if (idx_d == 6'(k)) word = buf_d[FRAME_W-1-k*WORD_W -: WORD_W];
        end
        data_d = {{(OUT_W-WORD_W){word[WORD_W-1]}}, word};
        last_d = valid_d && (idx_d == LAST_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments only; the frame buffer is reset too so
    // m_data never exposes stale or X contents after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            drop_q  <= '0;
`ifdef BOREAL_UNPACK_STATUS_CHECK_EN
            sync_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
`ifdef BOREAL_UNPACK_STATUS_CHECK_EN
            sync_q  <= sync_d;
`endif
        end
    end

    assign m_data     = data_q;
    assign m_valid    = valid_q;
    assign m_index    = idx_q;
    assign m_last     = last_q;
    assign busy       = (state_q == ST_STREAM);
    assign drop_count = drop_q;
`ifdef BOREAL_UNPACK_STATUS_CHECK_EN
    assign sync_err   = sync_q;
`else
    assign sync_err   = 16'd0;
`endif

endmodule

// File: tb/tb_boreal_frame_unpacker.sv
// Directed self-checking bench for boreal_frame_unpacker (default build and BOREAL_UNPACK_STATUS_CHECK_EN).
module tb_boreal_frame_unpacker;

    localparam int FW = 792;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [FW-1:0] frame_in;
    logic          frame_valid;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic [5:0]    m_index;
    logic          m_last;
    logic          busy;
    logic [15:0]   drop_count;
    logic [15:0]   sync_err;

    int passed = 0;
    int total  = 0;

    boreal_frame_unpacker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_index    (m_index),
        .m_last     (m_last),
        .busy       (busy),
        .drop_count (drop_count),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] make_frame(input logic [23:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < 33; k++) f[FW-1-k*24 -: 24] = base + 24'(k);
        return f;
    endfunction

    function automatic logic [31:0] exp_word(input logic [FW-1:0] f, input int k);
        logic [23:0] w;
        w = f[FW-1-k*24 -: 24];
        return {{8{w[23]}}, w};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, m_data, 32'h0);
        check({tag, "_valid"}, {31'h0, m_valid}, 32'h0);
        check({tag, "_index"}, {26'h0, m_index}, 32'h0);
        check({tag, "_last"}, {31'h0, m_last}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_drop"}, {16'h0, drop_count}, 32'h0);
        check({tag, "_sync"}, {16'h0, sync_err}, 32'h0);
    endtask

    task automatic start(input logic [FW-1:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check("start_valid", {31'h0, m_valid}, 32'h1);
        check("start_index", {26'h0, m_index}, 32'h0);
        check("start_busy", {31'h0, busy}, 32'h1);
    endtask

    // Streams words start_k..32 of f; optionally strobes inj_f while word inj_k is on the bus.
    task automatic consume(input logic [FW-1:0] f, input int start_k, input bit bp,
                           input int inj_k, input logic [FW-1:0] inj_f);
        bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int k   = start_k;
        int cyc = 0;
        while (k < 33 && cyc < 2000) begin
            m_ready     = bp ? pat[cyc % 8] : 1'b1;
            frame_valid = (k == inj_k && m_ready);
            frame_in    = inj_f;
            check("word_valid", {31'h0, m_valid}, 32'h1);
            check("word_index", {26'h0, m_index}, 32'(k));
            check("word_data", m_data, exp_word(f, k));
            check("word_last", {31'h0, m_last}, {31'h0, k == 32});
            if (m_ready) k++;
            step();
            cyc++;
        end
        frame_valid = 1'b0;
        check("stream_done", 32'(k), 32'd33);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, {31'h0, m_valid}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_index"}, {26'h0, m_index}, 32'h0);
    endtask

    initial begin
        logic [FW-1:0] fa, fb, fs, fbad;
        fa = make_frame(24'hC00000);
        fb = make_frame(24'hC00100);
        fs = fa;
        fs[FW-1-24 -: 24] = 24'h7FFFFF;
        fs[FW-1-48 -: 24] = 24'h800000;
        fbad = fb;
        fbad[FW-1 -: 24] = 24'h500000;

        // 1. reset held with a strobe present
        rst_n       = 1'b0;
        m_ready     = 1'b1;
        frame_in    = fa;
        frame_valid = 1'b1;
        repeat (3) step();
        check_reset_outputs("rst");
        frame_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        expect_idle("post_rst");

        // 2. full frame, m_ready held high
        start(fa);
        check("first_word_const", m_data, 32'hFFC00000);
        consume(fa, 0, 1'b0, -1, '0);
        expect_idle("a_end");

        // 3. sign extension
        m_ready = 1'b0;
        start(fs);
        step();
        check("stall_word0", m_data, 32'hFFC00000);
        m_ready = 1'b1;
        step();
        check("sext_pos_index", {26'h0, m_index}, 32'h1);
        check("sext_pos", m_data, 32'h007FFFFF);
        step();
        check("sext_neg", m_data, 32'hFF800000);
        consume(fs, 2, 1'b0, -1, '0);
        expect_idle("s_end");

        // 4. backpressure
        m_ready = 1'b0;
        start(fb);
        consume(fb, 0, 1'b1, -1, '0);
        expect_idle("bp_end");

        // 5a. strobe mid-stream is dropped
        start(fa);
        consume(fa, 0, 1'b0, 10, fb);
        check("drop_count_1", {16'h0, drop_count}, 32'd1);
        expect_idle("drop_end");

        // 5b. strobe on the last handshake chains the next frame
        start(fa);
        consume(fa, 0, 1'b0, 32, fb);
        check("chain_valid", {31'h0, m_valid}, 32'h1);
        check("chain_index", {26'h0, m_index}, 32'h0);
        check("chain_data", m_data, 32'hFFC00100);
        check("chain_drop", {16'h0, drop_count}, 32'd1);
        consume(fb, 0, 1'b0, -1, '0);
        expect_idle("chain_end");

        // 6. status header check
        frame_in    = fbad;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
`ifdef BOREAL_UNPACK_STATUS_CHECK_EN
        check("bad_hdr_valid", {31'h0, m_valid}, 32'h0);
        check("bad_hdr_busy", {31'h0, busy}, 32'h0);
        check("sync_err_1", {16'h0, sync_err}, 32'd1);
        step();
        check("bad_hdr_valid_late", {31'h0, m_valid}, 32'h0);
        start(fa);
        consume(fa, 0, 1'b0, -1, '0);
        expect_idle("good_after_bad");
`else
        check("nochk_valid", {31'h0, m_valid}, 32'h1);
        check("nochk_word0", m_data, 32'h00500000);
        check("nochk_sync", {16'h0, sync_err}, 32'd0);
        consume(fbad, 0, 1'b0, -1, '0);
        expect_idle("nochk_end");
`endif

        // reset asserted mid-stream abandons the frame
        start(fa);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();
        expect_idle("mid_rst_after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
